// File: rtl/split_eval_seq.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : split_eval_seq
// Purpose  : Sequential split-constraint evaluator. Variables arrive one per
//            cycle over a valid/ready stream. Each index must be delivered
//            exactly once; unique values are accumulated into a sum and an
//            XOR fold. Once NUM_VARS unique indices have been seen, the split
//            constraint is evaluated and x is returned over a valid/ready
//            result handshake.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            start      - begin a frame (IDLE only)
//            in_valid   - variable word valid
//            in_ready   - high exactly in COLLECT
//            in_idx     - variable index
//            in_data    - variable value (zero-extended by producer)
//            out_valid  - result valid, high exactly in DONE
//            out_ready  - result accepted (DONE only)
//            x          - registered constraint result
//            dup_err    - a duplicate index was seen this frame
//            range_err  - an index >= NUM_VARS was seen this frame
//            busy       - state != IDLE
// Revision : 1.0 - initial release
// ============================================================================
module split_eval_seq #(
    parameter int                                   NUM_VARS   = 30,
    parameter int                                   VAR_W      = 32,
    parameter logic [VAR_W+$clog2(NUM_VARS)-1:0]    SUM_LIMIT  = '1,
    parameter bit                                   PARITY_EN  = 1'b0,
    parameter bit                                   PARITY_VAL = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(NUM_VARS)-1:0]   in_idx,
    input  logic [VAR_W-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          x,
    output logic                          dup_err,
    output logic                          range_err,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_VARS);
    localparam int ACC_W = VAR_W + $clog2(NUM_VARS);
    // Counter must be able to represent NUM_VARS itself.
    localparam int CNT_W = $clog2(NUM_VARS + 1);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_VARS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [NUM_VARS-1:0]  r_seen;
    logic [ACC_W-1:0]     r_sum;
    logic [VAR_W-1:0]     r_xor;
    logic [CNT_W-1:0]     r_count;

    logic                 w_beat;
    logic                 w_idx_oob;
    logic                 w_idx_dup;
    logic                 w_new;
    logic                 w_last;
    logic                 w_eval_x;
    logic [31:0]          w_idx_ext;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    assign w_idx_ext = 32'(in_idx);
    assign w_beat    = in_valid && (r_state == S_COLLECT);
    assign w_idx_oob = (w_idx_ext >= 32'(NUM_VARS));
    // The seen-mask lookup is only meaningful for in-range indices.
    assign w_idx_dup = !w_idx_oob && r_seen[in_idx];
    assign w_new     = w_beat && !w_idx_oob && !w_idx_dup;
    assign w_last    = w_new && (r_count == c_LAST_CNT);

    assign w_eval_x  = (r_sum <= SUM_LIMIT)
                     && (!PARITY_EN || ((^r_xor) == PARITY_VAL))
                     && !dup_err
                     && !range_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (w_last) begin
                    w_next = S_EVAL;
                end
            end
            S_EVAL: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: seen mask, accumulators, flags and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen    <= '0;
            r_sum     <= '0;
            r_xor     <= '0;
            r_count   <= '0;
            x         <= 1'b0;
            dup_err   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_seen    <= '0;
                        r_sum     <= '0;
                        r_xor     <= '0;
                        r_count   <= '0;
                        x         <= 1'b0;
                        dup_err   <= 1'b0;
                        range_err <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_beat) begin
                        if (w_idx_oob) begin
                            range_err <= 1'b1;
                        end else if (w_idx_dup) begin
                            // First value wins; the repeat is dropped.
                            dup_err <= 1'b1;
                        end else begin
                            r_seen[in_idx] <= 1'b1;
                            r_sum          <= r_sum + {{(ACC_W-VAR_W){1'b0}}, in_data};
                            r_xor          <= r_xor ^ in_data;
                            r_count        <= r_count + CNT_W'(1);
                        end
                    end
                end
                S_EVAL: begin
                    x <= w_eval_x;
                end
                default: begin
                    // DONE: result and flags are held.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_split_eval_seq.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_split_eval_seq
// Purpose  : Self-checking bench for split_eval_seq. Three instances share
//            the stream buses: defaults (30 vars), a 4-var instance with
//            SUM_LIMIT=100, and a 2-var instance with parity enabled. Only
//            the selected instance receives start; the others sit in IDLE and
//            ignore the shared in_valid/out_ready. Expected results are
//            queued when a frame is launched and compared when out_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_split_eval_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [5:0]  idx_bus;
    logic [31:0] data_bus;
    logic [2:0]  start_v;
    logic [2:0]  rdy_v, val_v, x_v, dup_v, rng_v, busy_v;
    int          sel;

    split_eval_seq u_def (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .in_valid(in_valid), .in_ready(rdy_v[0]),
        .in_idx(idx_bus[4:0]), .in_data(data_bus),
        .out_valid(val_v[0]), .out_ready(out_ready),
        .x(x_v[0]), .dup_err(dup_v[0]), .range_err(rng_v[0]), .busy(busy_v[0])
    );

    split_eval_seq #(.NUM_VARS(4), .SUM_LIMIT(100)) u_lim (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .in_valid(in_valid), .in_ready(rdy_v[1]),
        .in_idx(idx_bus[1:0]), .in_data(data_bus),
        .out_valid(val_v[1]), .out_ready(out_ready),
        .x(x_v[1]), .dup_err(dup_v[1]), .range_err(rng_v[1]), .busy(busy_v[1])
    );

    split_eval_seq #(.NUM_VARS(2), .PARITY_EN(1'b1), .PARITY_VAL(1'b1)) u_par (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .in_valid(in_valid), .in_ready(rdy_v[2]),
        .in_idx(idx_bus[0:0]), .in_data(data_bus),
        .out_valid(val_v[2]), .out_ready(out_ready),
        .x(x_v[2]), .dup_err(dup_v[2]), .range_err(rng_v[2]), .busy(busy_v[2])
    );

    typedef struct packed {
        logic x;
        logic dup;
        logic rng;
    } exp_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic        pre;   // out_ready already high before the result
        logic [2:0]  n;
        logic [31:0] d0, d1, d2, d3;
        logic        ex_x;
    } vec_t;

    exp_t sb[$];
    vec_t vt [0:7];
    vec_t v;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rc;

    function automatic exp_t mk_exp(input logic ex, input logic ed, input logic er);
        exp_t e;
        e.x = ex; e.dup = ed; e.rng = er;
        return e;
    endfunction

    function automatic vec_t mk_vec(input int s, input logic p, input int n,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c, input logic [31:0] d,
                                    input logic ex);
        vec_t r;
        r.sel = s[1:0]; r.pre = p; r.n = n[2:0];
        r.d0 = a; r.d1 = b; r.d2 = c; r.d3 = d; r.ex_x = ex;
        return r;
    endfunction

    function automatic logic [31:0] vdata(input vec_t r, input int j);
        case (j)
            0:       return r.d0;
            1:       return r.d1;
            2:       return r.d2;
            default: return r.d3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic start_frame(input int s);
        sel     = s;
        start_v = 3'b001 << s;
        @(negedge clk);
        start_v = 3'b000;
        chk("ready after start", rdy_v[sel], 1);
        chk("dup cleared at start", dup_v[sel], 0);
        chk("range cleared at start", rng_v[sel], 0);
    endtask

    // Leaves in_valid high so consecutive calls stream back to back.
    task automatic send_beat(input int idx, input logic [31:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        idx_bus  = idx[5:0];
        data_bus = d;
        while (!rdy_v[sel] && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_v[sel]) chk("in_ready timeout", 0, 1);
        @(negedge clk);
    endtask

    // Must be called at the negedge right after the final accepting edge.
    task automatic wait_result(input string name);
        exp_t e;
        int   lat;
        lat      = 1;
        in_valid = 1'b0;
        while (!val_v[sel] && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, 2);
        if (sb.size() == 0) begin
            chk({name, " scoreboard empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({name, " x"}, x_v[sel], e.x);
            chk({name, " dup_err"}, dup_v[sel], e.dup);
            chk({name, " range_err"}, rng_v[sel], e.rng);
        end
    endtask

    task automatic accept_result(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " out_valid after accept"}, val_v[sel], 0);
        chk({name, " busy after accept"}, busy_v[sel], 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk_vec(1, 1'b0, 4, 10, 20, 30, 41, 1'b0);       // sum 101
        vt[1] = mk_vec(1, 1'b0, 4, 10, 20, 30, 40, 1'b1);       // sum 100
        vt[2] = mk_vec(1, 1'b1, 4, 0, 0, 0, 0, 1'b1);
        vt[3] = mk_vec(1, 1'b0, 4, 0, 0, 0, 101, 1'b0);
        vt[4] = mk_vec(2, 1'b0, 2, 1, 2, 0, 0, 1'b0);           // parity 0
        vt[5] = mk_vec(2, 1'b1, 2, 1, 3, 0, 0, 1'b1);           // parity 1
        vt[6] = mk_vec(2, 1'b0, 2, 0, 0, 0, 0, 1'b0);
        vt[7] = mk_vec(2, 1'b0, 2, 32'h8000_0000, 0, 0, 0, 1'b1);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        idx_bus   = '0;
        data_bus  = '0;
        start_v   = '0;
        sel       = 0;
        repeat (3) @(negedge clk);

        // Reset state of every instance; in_valid high must be ignored in IDLE.
        rst_n    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("reset busy", busy_v[s], 0);
            chk("reset in_ready", rdy_v[s], 0);
            chk("reset out_valid", val_v[s], 0);
            chk("reset x", x_v[s], 0);
            chk("reset dup_err", dup_v[s], 0);
            chk("reset range_err", rng_v[s], 0);
        end
        in_valid = 1'b0;

        // Default 30-variable frame, streamed back to back.
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b0));
        start_frame(0);
        rc = 0;
        for (int i = 0; i < 30; i++) begin
            if (rdy_v[sel]) rc++;
            send_beat(i, 32'(i));
        end
        chk("default in_ready drops", rdy_v[sel], 0);
        chk("default ready cycles", rc, 30);
        wait_result("default");
        accept_result("default");

        // Table-driven frames on the limit and parity instances.
        for (int k = 0; k < 8; k++) begin
            v         = vt[k];
            out_ready = v.pre;
            sb.push_back(mk_exp(v.ex_x, 1'b0, 1'b0));
            start_frame(int'(v.sel));
            for (int j = 0; j < int'(v.n); j++) begin
                send_beat(j, vdata(v, j));
            end
            wait_result($sformatf("vec%0d", k));
            accept_result($sformatf("vec%0d", k));
        end

        // Duplicate index: repeat is flagged and not counted.
        sb.push_back(mk_exp(1'b0, 1'b1, 1'b0));
        start_frame(1);
        send_beat(3, 5);
        send_beat(3, 99);
        chk("dup flag raised", dup_v[sel], 1);
        send_beat(0, 10);
        send_beat(1, 20);
        chk("dup not counted", rdy_v[sel], 1);
        send_beat(2, 30);
        wait_result("dup");
        accept_result("dup");
        chk("dup held after accept", dup_v[sel], 1);

        // Fresh frame after a failed one: flags cleared, sum at the limit.
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b0));
        start_frame(1);
        send_beat(3, 25);
        send_beat(0, 25);
        send_beat(1, 25);
        send_beat(2, 25);
        wait_result("fresh");
        accept_result("fresh");

        // Out-of-range index mid-frame on the 30-variable instance.
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b1));
        start_frame(0);
        for (int i = 0; i < 15; i++) send_beat(i, 32'(i));
        send_beat(31, 7);
        chk("range flag raised", rng_v[sel], 1);
        chk("range no dup", dup_v[sel], 0);
        for (int i = 15; i < 29; i++) send_beat(i, 32'(i));
        chk("range beat not counted", rdy_v[sel], 1);
        send_beat(29, 29);
        wait_result("range");
        accept_result("range");

        // Reset after 10 accepted beats aborts silently.
        start_frame(0);
        for (int i = 0; i < 10; i++) send_beat(i, 32'(i));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("abort busy", busy_v[sel], 0);
        chk("abort out_valid", val_v[sel], 0);
        chk("abort in_ready", rdy_v[sel], 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort no result", val_v[sel], 0);

        // DONE held with out_ready low; start during DONE ignored.
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b0));
        start_frame(1);
        send_beat(0, 10);
        send_beat(1, 20);
        send_beat(2, 30);
        send_beat(3, 40);
        wait_result("hold");
        for (int c = 0; c < 5; c++) begin
            start_v = (c == 2) ? 3'b010 : 3'b000;
            @(negedge clk);
            chk("hold out_valid", val_v[sel], 1);
            chk("hold x", x_v[sel], 1);
        end
        start_v = 3'b000;
        accept_result("hold");
        chk("x held in idle", x_v[sel], 1);
        @(negedge clk);
        chk("start in DONE ignored", busy_v[sel], 0);

        chk("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
